spi_slave_sync: RTL
===================

Name: spi_slave_sync

Overview:
- Successor to the asynchronous SPI slave. All logic runs on one system clock. sclk, cs_n and mosi are oversampled through synchronizers, so no logic is clocked by sclk.
- Supports all four CPOL/CPHA modes at run time and continuous multi-word transfers within one cs_n assertion.
- Both data paths use valid/ready handshakes. Status pulses flag underrun, overrun and frame errors.
- Sits between the SPI pins and a register/FIFO layer on the system clock.

Parameters:
- DATA_WIDTH, 8, bits per SPI word (≥2).
- MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first.
- SYNC_STAGES, 2, synchronizer depth on sclk, cs_n and mosi (≥2).
- TX_IDLE_BIT, 1, value of every bit of the word sent on TX underrun.

Ports:
- clk  input  1  system clock; sclk period must be ≥ 8 clk periods.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI serial clock from master (asynchronous).
- cs_n  input  1  chip select, active low (asynchronous).
- mosi  input  1  master out, slave in (asynchronous).
- cpol  input  1  clock polarity; latched at cs_n assertion.
- cpha  input  1  clock phase; latched at cs_n assertion.
- miso  output  1  slave out, master in data.
- miso_oe  output  1  miso output enable; external tristate buffer.
- tx_data  input  DATA_WIDTH  next word to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  1-clk pulse: tx_data consumed this cycle.
- rx_data  output  DATA_WIDTH  received word; held while rx_valid = 1.
- rx_valid  input/output: output  1  rx_data valid; held until rx_ready.
- rx_ready  input  1  consumer accepts rx_data.
- tx_underrun  output  1  1-clk pulse: word loaded while tx_valid = 0.
- rx_overrun  output  1  1-clk pulse: word completed while rx_valid = 1; new word dropped.
- frame_err  output  1  1-clk pulse: cs_n deasserted with a partial word (bit count 1..DATA_WIDTH-1).
- busy  output  1  high while a transaction is active (state ACTIVE).

Behaviour:
- Reset: all outputs 0 except miso = TX_IDLE_BIT. Shift registers and bit count clear; state = IDLE.
- Input sync: SYNC_STAGES flops on each input, then a 1-flop edge detect.
- Input-to-event latency: SYNC_STAGES+1 clk cycles.
- Edge definitions:
  - Leading edge: sclk leaves the latched cpol level. Trailing edge: sclk returns to it.
  - Sample edge: leading if cpha = 0, trailing if cpha = 1. Shift edge is the other one.
- State machine has two states, IDLE and ACTIVE.
  - IDLE → ACTIVE on synced cs_n fall. On this cycle: latch cpol/cpha, clear bit_cnt, assert miso_oe.
  - If cpha = 0, perform a TX load on the same cycle and drive its first bit on miso.
  - ACTIVE → IDLE on synced cs_n rise. On this cycle: deassert miso_oe, clear bit_cnt.
  - Pulse frame_err if bit_cnt is 1..DATA_WIDTH-1. A partial word is discarded.
- TX load:
  - If tx_valid = 1: take tx_data and pulse tx_ready.
  - Else: load an all-TX_IDLE_BIT word and pulse tx_underrun.
- Shift edge:
  - If cpha = 1 and bit_cnt = 0: TX load, then drive the first bit.
  - If cpha = 0 and bit_cnt = 0 (the shift edge right after a word completes): TX load for the next word, then drive its first bit.
  - Otherwise drive the next bit of the TX shift register.
  - Bit order follows MSB_FIRST.
- Sample edge:
  - Shift synced mosi into the RX register and increment bit_cnt.
  - When the count reaches DATA_WIDTH, reset bit_cnt to 0 and complete the word.
- Word completion:
  - If rx_valid = 0 or rx_ready = 1 this cycle: rx_data ← word, rx_valid = 1 on the next cycle.
  - Else: drop the word and pulse rx_overrun.
- rx_valid clears on the cycle after rx_valid & rx_ready when no new word completes.
- Simultaneous completion and accept counts as accept-then-load: no overrun.
- cpol/cpha changes while ACTIVE are ignored.
- A cs_n rise coincident with a sclk edge: the cs_n rise wins; the edge is ignored.
- sclk edges in IDLE are ignored.
- Reset mid-transfer aborts immediately. There are no pulses; the master restarts the frame.

Decomposition:
- Package spi_pkg holds:
  - Mode encoding constants MODE0..MODE3 = {cpol, cpha}.
  - State constants ST_IDLE and ST_ACTIVE.
  - A bit-count width function clog2(DATA_WIDTH+1).
- One sub-module, spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs.
  - Instantiated for sclk and cs_n; mosi uses the synchronizer output only.

Test Plan:
- Mode 0, one word:
  - Stimulus: tx_valid with tx_data 0x3C; master sends 0xA5.
  - Response: miso bits 0,0,1,1,1,1,0,0; rx_data = 0xA5 with rx_valid; one tx_ready pulse at cs_n fall.
- Mode 3, back-to-back words:
  - Stimulus: two words 0x81, 0x7E in one cs_n; tx words 0x55, 0xAA, both presented before their load.
  - Response: master receives 0x55 then 0xAA; rx_data 0x81 then 0x7E; two tx_ready pulses; no error pulses.
- Underrun and overrun:
  - Stimulus: mode 1, tx_valid = 0, rx_ready = 0; master sends two words.
  - Response: master receives 0xFF twice; two tx_underrun pulses; rx_data = word 1; one rx_overrun pulse on word 2.
- Frame error and reset:
  - Stimulus: mode 2, cs_n released after 5 bits.
  - Response: one frame_err pulse, no rx_valid; the next full frame is received correctly.
  - Stimulus: rst asserted mid-word.
  - Response: all outputs at reset values, miso_oe = 0.
- LSB-first:
  - Stimulus: MSB_FIRST = 0, DATA_WIDTH = 16; tx 0x1234, master sends 0xBEEF in mode 0.
  - Response: miso LSB-first sequence of 0x1234; rx_data = 0xBEEF.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared encodings and sizing helpers for the oversampled SPI slave.
package spi_pkg;

  // SPI mode encoding, {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Width of a counter that must hold 0..dw
  function automatic int bit_cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, followed by a one-flop
// edge detector producing single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              lvl;

  // Synchronizer chain plus the previous-level flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign lvl    = sync_q[STAGES-1];
  assign rise_o = lvl & ~prev_q;
  assign fall_o = ~lvl & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave running entirely on the system clock. sclk/cs_n/mosi are
// oversampled; all four CPOL/CPHA modes are selected at cs_n assertion.
// TX and RX words move through valid/ready handshakes with status pulses
// for underrun, overrun and truncated frames.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2,
  parameter bit TX_IDLE_BIT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  input  logic                  cpol,
  input  logic                  cpha,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  tx_underrun,
  output logic                  rx_overrun,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int                    CW        = bit_cnt_w(DATA_WIDTH);
  localparam logic [CW-1:0]         LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {DATA_WIDTH{TX_IDLE_BIT}};

  // Synchronized events
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   mosi_s;

  // State
  state_e                state_q;
  logic                  cpol_q, cpha_q;
  logic [CW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] tx_sr_q;
  logic [DATA_WIDTH-2:0] rx_sr_q;   // only the partial bits of a word
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  miso_q, miso_oe_q;
  logic                  tx_ready_q, tx_underrun_q, rx_overrun_q, frame_err_q;

  // Next-state / decode
  logic                  sample_ev, shift_ev;
  logic                  active, load_now, shift_now, sample_now, word_done;
  logic [DATA_WIDTH-1:0] tx_src, tx_sr_d;
  logic                  miso_d;
  logic [DATA_WIDTH-1:0] rx_word;
  logic                  rx_accept;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // cs_n resets to its inactive level so reset release never fakes a select
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (cs_n),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // mosi only needs its level; matching depth keeps it aligned with sclk edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Map raw sclk edges onto sample/shift edges for the latched mode
  always_comb begin
    sample_ev = 1'b0;
    shift_ev  = 1'b0;
    case ({cpol_q, cpha_q})
      MODE0, MODE3: begin sample_ev = sclk_rise; shift_ev = sclk_fall; end
      MODE1, MODE2: begin sample_ev = sclk_fall; shift_ev = sclk_rise; end
      default: ;
    endcase
  end

  // Qualify events; a cs_n rise masks any coincident sclk edge
  always_comb begin
    active     = (state_q == ST_ACTIVE) && !cs_rise;
    load_now   = ((state_q == ST_IDLE) && cs_fall && !cpha) ||
                 (active && shift_ev && (bit_cnt_q == '0));
    shift_now  = active && shift_ev && (bit_cnt_q != '0);
    sample_now = active && sample_ev;
    word_done  = sample_now && (bit_cnt_q == LAST_BIT);
    rx_accept  = !rx_valid_q || rx_ready;
  end

  // TX path: a load feeds the fresh word through the same bit-pick as a shift
  always_comb begin
    tx_src  = load_now ? (tx_valid ? tx_data : IDLE_WORD) : tx_sr_q;
    miso_d  = MSB_FIRST ? tx_src[DATA_WIDTH-1] : tx_src[0];
    tx_sr_d = MSB_FIRST ? (tx_src << 1) : (tx_src >> 1);
    rx_word = MSB_FIRST ? {rx_sr_q, mosi_s} : {mosi_s, rx_sr_q};
  end

  // Transaction FSM with registered outputs and datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      bit_cnt_q     <= '0;
      tx_sr_q       <= '0;
      rx_sr_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      miso_q        <= TX_IDLE_BIT;
      miso_oe_q     <= 1'b0;
      tx_ready_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      tx_ready_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
      frame_err_q   <= 1'b0;

      if (load_now || shift_now) begin
        miso_q  <= miso_d;
        tx_sr_q <= tx_sr_d;
      end
      if (load_now) begin
        tx_ready_q    <= tx_valid;
        tx_underrun_q <= !tx_valid;
      end

      if (sample_now) begin
        rx_sr_q   <= MSB_FIRST ? rx_word[DATA_WIDTH-2:0] : rx_word[DATA_WIDTH-1:1];
        bit_cnt_q <= word_done ? '0 : bit_cnt_q + 1'b1;
      end

      // Accept clears first so a same-cycle completion reloads without overrun
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      if (word_done) begin
        if (rx_accept) begin
          rx_data_q  <= rx_word;
          rx_valid_q <= 1'b1;
        end else begin
          rx_overrun_q <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q   <= ST_ACTIVE;
            cpol_q    <= cpol;
            cpha_q    <= cpha;
            bit_cnt_q <= '0;
            miso_oe_q <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state_q     <= ST_IDLE;
            miso_oe_q   <= 1'b0;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            frame_err_q <= (bit_cnt_q != '0);
          end
        end
      endcase
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = tx_ready_q;
  assign tx_underrun = tx_underrun_q;
  assign rx_overrun  = rx_overrun_q;
  assign frame_err   = frame_err_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q == ST_ACTIVE);

endmodule
